// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter for the single HyperBus PHY transaction channel.
// One requester owns the channel from ISSUE until its last read beat or its
// write response; write data, read data and responses are routed to the owner
// only, combinationally and with no added latency.
module hyperbus_trans_arbiter #(
    parameter  int NR_REQ      = 2,
    parameter  int NR_CS       = 2,
    parameter  int BURST_WIDTH = 12,
    localparam int IW          = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // requester transaction channel
    input  logic [NR_REQ-1:0]             req_valid_i,
    output logic [NR_REQ-1:0]             req_ready_o,
    input  logic [NR_REQ*NR_CS-1:0]       req_cs_i,
    input  logic [NR_REQ-1:0]             req_write_i,
    input  logic [NR_REQ-1:0]             req_burst_type_i,
    input  logic [NR_REQ-1:0]             req_address_space_i,
    input  logic [NR_REQ*BURST_WIDTH-1:0] req_burst_i,
    input  logic [NR_REQ*32-1:0]          req_address_i,
    // requester write data
    input  logic [NR_REQ-1:0]             req_tx_valid_i,
    output logic [NR_REQ-1:0]             req_tx_ready_o,
    input  logic [NR_REQ*16-1:0]          req_tx_data_i,
    input  logic [NR_REQ*2-1:0]           req_tx_strb_i,
    // requester read data
    output logic [NR_REQ-1:0]             req_rx_valid_o,
    input  logic [NR_REQ-1:0]             req_rx_ready_i,
    output logic [15:0]                   req_rx_data_o,
    output logic                          req_rx_last_o,
    output logic                          req_rx_error_o,
    // requester write response
    output logic [NR_REQ-1:0]             req_b_valid_o,
    output logic                          req_b_error_o,
    // PHY transaction channel
    output logic                          trans_valid_o,
    input  logic                          trans_ready_i,
    output logic [NR_CS-1:0]              trans_cs_o,
    output logic                          trans_write_o,
    output logic [BURST_WIDTH-1:0]        trans_burst_o,
    output logic                          trans_burst_type_o,
    output logic                          trans_address_space_o,
    output logic [31:0]                   trans_address_o,
    // PHY write data
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic [15:0]                   tx_data_o,
    output logic [1:0]                    tx_strb_o,
    // PHY read data
    input  logic                          rx_valid_i,
    output logic                          rx_ready_o,
    input  logic [15:0]                   rx_data_i,
    input  logic                          rx_last_i,
    input  logic                          rx_error_i,
    // PHY write response
    input  logic                          b_valid_i,
    input  logic                          b_error_i,
    // debug
    output logic [IW-1:0]                 owner_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, READ, WRITE} state_t;

    state_t        state, state_d;
    logic [IW-1:0] owner, owner_d;
    logic [IW-1:0] rr_ptr, rr_ptr_d;
    logic [IW-1:0] pick;
    logic          any_req;
    logic [IW-1:0] next_ptr;
    int            scan;

    logic [NR_CS-1:0]       cs_arr    [NR_REQ];
    logic [BURST_WIDTH-1:0] burst_arr [NR_REQ];
    logic [31:0]            addr_arr  [NR_REQ];
    logic [15:0]            txd_arr   [NR_REQ];
    logic [1:0]             strb_arr  [NR_REQ];

    for (genvar k = 0; k < NR_REQ; k++) begin : g_unpack
        assign cs_arr[k]    = req_cs_i[k*NR_CS +: NR_CS];
        assign burst_arr[k] = req_burst_i[k*BURST_WIDTH +: BURST_WIDTH];
        assign addr_arr[k]  = req_address_i[k*32 +: 32];
        assign txd_arr[k]   = req_tx_data_i[k*16 +: 16];
        assign strb_arr[k]  = req_tx_strb_i[k*2 +: 2];
    end

    // Wrap with an explicit compare so non-power-of-2 NR_REQ works.
    assign next_ptr = (owner == IW'(NR_REQ - 1)) ? '0 : owner + IW'(1);
    assign owner_o  = owner;

    // Round-robin pick: first valid requester scanning upward from rr_ptr.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        scan    = 0;
        for (int i = 0; i < NR_REQ; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NR_REQ) scan = scan - NR_REQ;
            if (!any_req && req_valid_i[scan[IW-1:0]]) begin
                any_req = 1'b1;
                pick    = scan[IW-1:0];
            end
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Next-state logic and owner-routed outputs; everything idles at zero.
    always_comb begin
        state_d               = state;
        owner_d               = owner;
        rr_ptr_d              = rr_ptr;
        req_ready_o           = '0;
        req_tx_ready_o        = '0;
        req_rx_valid_o        = '0;
        req_rx_data_o         = '0;
        req_rx_last_o         = 1'b0;
        req_rx_error_o        = 1'b0;
        req_b_valid_o         = '0;
        req_b_error_o         = 1'b0;
        trans_valid_o         = 1'b0;
        trans_cs_o            = '0;
        trans_write_o         = 1'b0;
        trans_burst_o         = '0;
        trans_burst_type_o    = 1'b0;
        trans_address_space_o = 1'b0;
        trans_address_o       = '0;
        tx_valid_o            = 1'b0;
        tx_data_o             = '0;
        tx_strb_o             = '0;
        rx_ready_o            = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                trans_valid_o         = 1'b1;
                trans_cs_o            = cs_arr[owner];
                trans_write_o         = req_write_i[owner];
                trans_burst_o         = burst_arr[owner];
                trans_burst_type_o    = req_burst_type_i[owner];
                trans_address_space_o = req_address_space_i[owner];
                trans_address_o       = addr_arr[owner];
                req_ready_o[owner]    = trans_ready_i;
                if (trans_ready_i) begin
                    state_d = req_write_i[owner] ? WRITE : READ;
                end
            end
            READ: begin
                req_rx_valid_o[owner] = rx_valid_i;
                rx_ready_o            = req_rx_ready_i[owner];
                req_rx_data_o         = rx_data_i;
                req_rx_last_o         = rx_last_i;
                req_rx_error_o        = rx_error_i;
                if (rx_valid_i && req_rx_ready_i[owner] && rx_last_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            WRITE: begin
                tx_valid_o            = req_tx_valid_i[owner];
                req_tx_ready_o[owner] = tx_ready_i;
                tx_data_o             = txd_arr[owner];
                tx_strb_o             = strb_arr[owner];
                if (b_valid_i) begin
                    req_b_valid_o[owner] = 1'b1;
                    req_b_error_o        = b_error_i;
                    state_d              = IDLE;
                    rr_ptr_d             = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
